part_74ls161: RTL and testbench



---
 rtl/part_74ls161.sv | 165 ++++++++++++++++
 tb/tb_part_74ls161.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/part_74ls161.sv
// part_74ls161 -- 74LS161 synchronous 4-bit binary counter with asynchronous
// clear, for board-level simulation. Cascades through ent/rco.
//
// Ports:
//   clk     counter clock, all synchronous actions on the rising edge
//   clr_n   asynchronous active-low clear, overrides load and count
//   load_n  synchronous parallel load, active low (beats enp/ent)
//   enp     count enable P
//   ent     count enable T, also gates rco
//   d[3:0]  parallel load data, d[0] is the LSB
//   q[3:0]  counter state
//   rco     ripple carry, ent & (q == 4'hF), purely combinational
//
// Parameters: TPD (output delay), TSU/TH (setup/hold of d, load_n, enp, ent),
// TREC (clr_n recovery). This model is cycle-based: q moves on the clock edge
// or on the clr_n fall. TSU/TH/TREC are only acted on in the timing-check build.
//
// Optional build: define CHIP_TIMING_CHECK_EN to enable setup/hold/recovery
// checks. A violation prints a warning, bumps `violations` and poisons q to X.
// q stays X until a clear or a clean load.
//
// state    | meaning
// cleared  | clr_n low, or released with no falling clk edge seen yet: q = 0, rising edges ignored
// count[n] | q = n (0..15): load, count or hold on each rising edge
module part_74ls161 #(
    parameter int TPD  = 0,
    parameter int TSU  = 20,
    parameter int TH   = 0,
    parameter int TREC = 15
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    if (TPD < 0 || TSU < 0 || TH < 0 || TREC < 0) begin : g_param_check
        $error("part_74ls161: timing parameters must be non-negative");
    end

    logic       armed;
    logic [3:0] cnt_val;
    logic [3:0] q_next;

    // armed rises on the first falling clk edge after clr_n is released, so a
    // rising edge coincident with the release is always ignored and counting
    // resumes on the first full clock cycle.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // The explicit true/false branches let an unknown control bit fall
    // through to X instead of silently picking a branch.
    always_comb begin
        cnt_val = q;
        if (enp && ent) begin
            cnt_val = q + 4'd1;
        end else if (!(enp && ent)) begin
            cnt_val = q;
        end else begin
            cnt_val = 4'bxxxx;
        end
    end

    always_comb begin
        q_next = q;
        if (!load_n) begin
            q_next = d;
        end else if (load_n) begin
            q_next = cnt_val;
        end else begin
            // load_n unknown: result is only defined where load and count agree
            q_next = (d == cnt_val) ? d : 4'bxxxx;
        end
    end

`ifdef CHIP_TIMING_CHECK_EN
    integer violations = 0;
    longint t_d        = -64'sd1000000;
    longint t_load     = -64'sd1000000;
    longint t_enp      = -64'sd1000000;
    longint t_ent      = -64'sd1000000;
    longint t_clr_rel  = -64'sd1000000;
    longint t_edge     = -64'sd1000000;
    longint t_edge_new = -64'sd1000000;

    always @(d)             t_d       = longint'($time);
    always @(load_n)        t_load    = longint'($time);
    always @(enp)           t_enp     = longint'($time);
    always @(ent)           t_ent     = longint'($time);
    always @(posedge clr_n) t_clr_rel = longint'($time);

    // t_edge holds the previous rising edge while the current one is being
    // checked; it is only advanced on the falling edge to avoid a same-time race.
    always @(posedge clk) t_edge_new = longint'($time);
    always @(negedge clk) t_edge     = t_edge_new;

    function automatic bit sig_hit(input longint t_chg);
        longint now;
        now = longint'($time);
        return ((now - t_chg) < longint'(TSU)) ||
               ((t_chg >= t_edge) && (t_edge < now) && ((t_chg - t_edge) < longint'(TH)));
    endfunction

    function automatic bit rec_hit();
        return (longint'($time) - t_clr_rel) < longint'(TREC);
    endfunction

    function automatic bit any_hit();
        return sig_hit(t_d) || sig_hit(t_load) || sig_hit(t_enp) || sig_hit(t_ent) || rec_hit();
    endfunction

    always @(posedge clk) begin
        if (clr_n === 1'b1) begin
            if (sig_hit(t_d)) begin
                violations = violations + 1;
                $display("part_74ls161 timing warning at %0t: d", $time);
            end
            if (sig_hit(t_load)) begin
                violations = violations + 1;
                $display("part_74ls161 timing warning at %0t: load_n", $time);
            end
            if (sig_hit(t_enp)) begin
                violations = violations + 1;
                $display("part_74ls161 timing warning at %0t: enp", $time);
            end
            if (sig_hit(t_ent)) begin
                violations = violations + 1;
                $display("part_74ls161 timing warning at %0t: ent", $time);
            end
            if (rec_hit()) begin
                violations = violations + 1;
                $display("part_74ls161 timing warning at %0t: clr_n recovery", $time);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 4'h0;
        end else if (clr_n) begin
            if (armed) begin
`ifdef CHIP_TIMING_CHECK_EN
                q <= any_hit() ? 4'bxxxx : q_next;
`else
                q <= q_next;
`endif
            end
        end else begin
            q <= 4'bxxxx;
        end
    end

    assign rco = ent & (q == 4'hF);

endmodule

// File: tb/tb_part_74ls161.sv
module tb_part_74ls161;

    logic       clk    = 1'b1;
    logic       clr_n  = 1'b1;
    logic       load_n = 1'b1;
    logic       enp    = 1'b0;
    logic       ent    = 1'b0;
    logic [3:0] d_lo   = 4'h0;
    logic [3:0] d_hi   = 4'h0;
    logic [3:0] q_lo;
    logic [3:0] q_hi;
    logic       rco_lo;
    logic       rco_hi;
    logic       jk_flag = 1'b0;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     m_lo  = 0;
    int     m_hi  = 0;
    longint t_rel = 0;

    // falling edges at 5, 15, ...; rising edges at 10, 20, ...
    always #5 clk = ~clk;

    part_74ls161 u_lo (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_n (load_n),
        .enp    (enp),
        .ent    (ent),
        .d      (d_lo),
        .q      (q_lo),
        .rco    (rco_lo)
    );

    part_74ls161 u_hi (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_n (load_n),
        .enp    (enp),
        .ent    (rco_lo),
        .d      (d_hi),
        .q      (q_hi),
        .rco    (rco_hi)
    );

    // stand-in for the downstream JK flop: J = high-stage rco, K = 0
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) jk_flag <= 1'b0;
        else if (rco_hi) jk_flag <= 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference: an 8-bit cascade, low nibble carries into high nibble.
    task automatic model_edge();
        int carry;
        if (clr_n && (longint'($time) - t_rel) >= 5) begin
            if (!load_n) begin
                m_lo = int'(d_lo);
                m_hi = int'(d_hi);
            end else if (enp) begin
                carry = (ent && m_lo == 15) ? 1 : 0;
                if (ent) m_lo = (m_lo + 1) % 16;
                if (carry == 1) m_hi = (m_hi + 1) % 16;
            end
        end
    endtask

    task automatic compare(input string tag);
        int lo_carry;
        lo_carry = (ent && m_lo == 15) ? 1 : 0;
        check({tag, ".q_lo"},   int'(q_lo),   m_lo);
        check({tag, ".q_hi"},   int'(q_hi),   m_hi);
        check({tag, ".rco_lo"}, int'(rco_lo), lo_carry);
        check({tag, ".rco_hi"}, int'(rco_hi), (lo_carry == 1 && m_hi == 15) ? 1 : 0);
    endtask

    task automatic drive(input logic c, input logic l, input logic p, input logic t,
                         input logic [3:0] dl, input logic [3:0] dh);
        if (c && !clr_n) t_rel = longint'($time);
        clr_n  = c;
        load_n = l;
        enp    = p;
        ent    = t;
        d_lo   = dl;
        d_hi   = dh;
        if (!c) begin
            m_lo = 0;
            m_hi = 0;
        end
    endtask

    task automatic drive_cmp(input logic c, input logic l, input logic p, input logic t,
                             input logic [3:0] dl, input logic [3:0] dh);
        drive(c, l, p, t, dl, dh);
        #1 compare("drv");
    endtask

    task automatic edge_step(input string tag);
        @(posedge clk);
        model_edge();
        #1 compare(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // clear at t=0, release coincident with the first rising edge at t=10
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        #1 compare("reset");
        check("reset_q_lit", int'(q_lo), 0);
        check("reset_rco_lit", int'(rco_lo), 0);
        @(posedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        model_edge();
        #1 compare("rel_at_edge");
        check("rel_at_edge_lit", int'(q_lo), 0);

        for (int k = 1; k <= 16; k++) begin
            edge_step("count");
            check("count_lit", int'(q_lo), k % 16);
            check("count_rco_lit", int'(rco_lo), (k == 15) ? 1 : 0);
        end
        check("carry_hi_lit", int'(q_hi), 1);

        // load priority over count
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 4'h0);
        edge_step("ld5");
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 4'h0);
        edge_step("ld_pri");
        check("ld_pri_lit", int'(q_lo), 10);

        // enable hold
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0);
        edge_step("ld3");
        drive_cmp(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            edge_step("hold_p");
            check("hold_p_lit", int'(q_lo), 3);
        end
        drive_cmp(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            edge_step("hold_t");
            check("hold_t_lit", int'(q_lo), 3);
            check("hold_t_rco_lit", int'(rco_lo), 0);
        end

        // rco gated by ent at q = F, no clock needed
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        edge_step("ldF");
        check("rco_ent0_lit", int'(rco_lo), 0);
        drive_cmp(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        check("rco_ent1_lit", int'(rco_lo), 1);

        // async clear mid-count, then release on an edge
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 4'h0);
        edge_step("ld9");
        check("ld9_lit", int'(q_lo), 9);
        drive_cmp(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        check("async_clr_lit", int'(q_lo), 0);
        @(posedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        model_edge();
        #1 compare("clr_rel_edge");
        check("clr_rel_edge_lit", int'(q_lo), 0);
        edge_step("resume");
        check("resume_lit", int'(q_lo), 1);

        // 8-bit cascade from 8'hFE into the JK stand-in
        drive_cmp(1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 4'hF);
        edge_step("ldFE");
        drive_cmp(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        edge_step("casc1");
        check("casc_ff_lit", int'({q_hi, q_lo}), 8'hFF);
        check("casc_rco_hi_lit", int'(rco_hi), 1);
        check("casc_jk0_lit", int'(jk_flag), 0);
        edge_step("casc2");
        check("casc_00_lit", int'({q_hi, q_lo}), 8'h00);
        check("casc_jk1_lit", int'(jk_flag), 1);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            drive_cmp(($urandom_range(0, 15) != 0),
                      ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0),
                      4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
            edge_step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
